// File: rtl/reg_dump.sv
// Register-file dump engine: walks first_idx..last_idx through a synchronous
// read port and presents each value on a valid/ready stream.
module reg_dump #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_idx,
  input  logic [AW-1:0] last_idx,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    FETCH,
    SEND,
    DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_q;

  // ra, busy and done are registered alongside the state transition so that
  // every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      last_q    <= '0;
      ra        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (first_idx <= last_idx) begin
              idx    <= first_idx;
              last_q <= last_idx;
              ra     <= first_idx;
              state  <= ISSUE;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ISSUE: state <= FETCH;
        FETCH: begin
          out_data  <= rdata;
          out_idx   <= idx;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before incrementing so last_idx = 2**AW-1 never wraps.
            if (idx == last_q) begin
              ra    <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              ra    <= idx + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          ra    <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter DW, default 32, width of register data read back from the register file.
REQ-002 Parameter AW, default 5, width of register index (32 registers).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to dump registers first_idx..last_idx; sampled only in IDLE.
REQ-006 first_idx  input  AW  first register index; latched when start is accepted.
REQ-007 last_idx  input  AW  last register index, inclusive; latched when start is accepted.
REQ-008 ra  output  AW  read address to the register file's synchronous read port.
REQ-009 rdata  input  DW  register file read data; equals regs[ra] as sampled on the previous clk edge.
REQ-010 out_valid  output  1  out_data/out_idx hold a valid register value.
REQ-011 out_ready  input  1  consumer accepts the transfer when high together with out_valid.
REQ-012 out_data  output  DW  dumped register value.
REQ-013 out_idx  output  AW  index of out_data.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a dump.

Function
REQ-016 The block SHALL be a registered FSM with states IDLE, ISSUE, FETCH, SEND and DONE; all outputs are registered or decoded from state only.
REQ-017 IDLE: start=1 with first_idx<=last_idx SHALL latch both indices, load idx<=first_idx and go to ISSUE.
REQ-018 IDLE: start=1 with first_idx>last_idx SHALL go directly to DONE with no transfer.
REQ-019 ra SHALL equal the internal idx in ISSUE, FETCH and SEND, and 0 in IDLE and DONE.
REQ-020 ISSUE SHALL last exactly one cycle then go to FETCH (the register file samples regs[idx] at this edge).
REQ-021 FETCH SHALL last exactly one cycle; at its ending edge out_data<=rdata, out_idx<=idx, out_valid<=1, state<=SEND.
REQ-022 SEND: out_valid, out_data and out_idx SHALL remain stable until the cycle in which out_ready=1.
REQ-023 SEND with out_ready=1: out_valid<=0; if idx==last_idx go to DONE, else idx<=idx+1 and go to ISSUE.
REQ-024 idx SHALL never wrap; last_idx=31 terminates after index 31 without incrementing to 0.
REQ-025 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 start while not in IDLE SHALL be ignored; first_idx and last_idx changes after acceptance SHALL have no effect.
REQ-027 Timing: start sampled in cycle N -> ISSUE N+1, FETCH N+2, out_valid high from N+3; with out_ready held high, one transfer every 3 cycles.
REQ-028 Final handshake in cycle M -> done=1 in cycle M+1, busy=0 and IDLE in cycle M+2; a new start is accepted in M+2.
REQ-029 Register-file writes to idx that occur after the FETCH edge SHALL NOT alter the captured out_data.

Reset
REQ-030 rst=1 at a clk edge SHALL force IDLE, idx=0, ra=0, out_valid=0, out_data=0, out_idx=0, busy=0 and done=0, from any state including mid-transfer.
REQ-031 rst SHALL take priority over start and out_ready in the same cycle.

Verification
REQ-032 Regs preloaded regs[k]=k*0x1111; start, first=0, last=31, out_ready=1 -> 32 transfers, out_idx 0..31 in order, out_data=k*0x1111, done one cycle after the index-31 handshake.
REQ-033 first=5, last=7, out_ready low for 4 cycles on each transfer -> out_data/out_idx stable while stalled, exactly 3 transfers (5,6,7), then done.
REQ-034 first=9, last=3 -> no out_valid, done in cycle N+1, busy high only in cycle N+1.
REQ-035 first=last=31 -> single transfer with out_idx=31, ra never 0 during the dump, no wrap to index 0.
REQ-036 rst asserted in SEND during a 0..31 dump -> all outputs zero next cycle; a subsequent start runs a complete dump correctly.
REQ-037 start pulsed again while busy, and first_idx/last_idx changed mid-dump -> dump sequence unchanged, exactly one done pulse.
